pipe_stage_latch: RTL

Parametrised inter-stage pipeline register for the five-stage processor. It generalises the fixed 32-bit stage latches to configurable data width and carries a valid bit. It supports stall (hold) and flush (bubble insertion), and keeps a saturating stall-cycle counter for performance monitoring. One instance sits between each adjacent pair of stages (F/D, D/X, X/M, M/W).

---
 rtl/pipe_stage_latch_pkg.sv | 12 +
 rtl/pipe_stage_latch_reg.sv | 16 +
 rtl/pipe_stage_latch.sv | 49 ++++
 3 files changed

// File: rtl/pipe_stage_latch_pkg.sv
// pipe_stage_latch_pkg: shared pipeline defaults and stage-latch action encoding
package pipe_stage_latch_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int INS_W_DEF = 32;
  localparam logic [63:0] NOP_INS_DEF = 64'h0;
  typedef enum logic [1:0] {
    ACT_RESET = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_HOLD  = 2'd2,
    ACT_LOAD  = 2'd3
  } act_e;
endpackage

// File: rtl/pipe_stage_latch_reg.sv
// pipe_reg: enabled register with synchronous active-low reset and clear to CLR_VAL
module pipe_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk)
    if (!reset || clr_i) q_o <= CLR_VAL;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: inter-stage pipeline register with stall, flush and saturating stall counter
module pipe_stage_latch
  import pipe_stage_latch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int INS_W = INS_W_DEF,
  parameter int CNT_W = 16,
  parameter logic [63:0] NOP_INS = NOP_INS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              valid_in,
  input  logic [INS_W-1:0]  ins_in,
  input  logic [DATA_W-1:0] o_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic              ovf_in,
  output logic              valid_out,
  output logic [INS_W-1:0]  ins_out,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] d_out,
  output logic              ovf_out,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam logic [INS_W-1:0] NOP = INS_W'(NOP_INS);
  act_e act;
  logic ld, bub;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    act = !reset ? ACT_RESET : flush ? ACT_FLUSH : stall ? ACT_HOLD : ACT_LOAD;
    ld = act == ACT_LOAD;
    bub = act == ACT_FLUSH || (ld && !valid_in);
    cnt_d = cnt_clr ? '0 : (act == ACT_HOLD && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
  assign stall_cnt = cnt_q;
  pipe_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en_i(ld), .clr_i(act == ACT_FLUSH), .d_i(valid_in), .q_o(valid_out));
  pipe_reg #(.WIDTH(INS_W), .CLR_VAL(NOP)) u_ins (
    .clk(clk), .reset(reset), .en_i(ld), .clr_i(bub), .d_i(ins_in), .q_o(ins_out));
  pipe_reg #(.WIDTH(DATA_W)) u_o (
    .clk(clk), .reset(reset), .en_i(ld), .clr_i(bub), .d_i(o_in), .q_o(o_out));
  pipe_reg #(.WIDTH(DATA_W)) u_d (
    .clk(clk), .reset(reset), .en_i(ld), .clr_i(bub), .d_i(d_in), .q_o(d_out));
  pipe_reg #(.WIDTH(1)) u_ovf (
    .clk(clk), .reset(reset), .en_i(ld), .clr_i(bub), .d_i(ovf_in), .q_o(ovf_out));
endmodule
